// File: rtl/main_mem_responder.sv
// main_mem_responder
//   Line-granular main-memory responder for the cache-to-memory interface.
//   It accepts one line read or line write at a time. After a fixed latency it
//   completes the transfer and pulses ca_resp. The pulse is self-timed and is
//   never gated by the request line.
//
// Ports
//   clk        : clock
//   rst        : synchronous reset, active-high
//   mem_read   : line read request (level)
//   mem_write  : line write request (level); wins when both requests are high
//   mem_addr   : byte address; only the line-index bits are used
//   mem_wdata  : write line, word 0 in the LSBs
//   mem_rdata  : read line, registered, held until the next read response
//   ca_resp    : completion pulse, RESP_CYCLES wide
//   proto_err  : one-cycle pulse when read and write are requested together
module main_mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned WORD_WIDTH  = 32,
   parameter int unsigned LINE_WORDS  = 8,
   parameter int unsigned DEPTH_LINES = 256,
   parameter int unsigned RD_LATENCY  = 4,
   parameter int unsigned WR_LATENCY  = 4,
   parameter int unsigned RESP_CYCLES = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             mem_read,
   input  logic                             mem_write,
   input  logic [ADDR_WIDTH-1:0]            mem_addr,
   input  logic [LINE_WORDS*WORD_WIDTH-1:0] mem_wdata,
   output logic [LINE_WORDS*WORD_WIDTH-1:0] mem_rdata,
   output logic                             ca_resp,
   output logic                             proto_err
);

   localparam int unsigned LINE_BITS = LINE_WORDS * WORD_WIDTH;
   localparam int unsigned OFF       = $clog2(LINE_BITS / 8);
   localparam int unsigned IDX_W     = $clog2(DEPTH_LINES);
   localparam int unsigned RD_M1     = RD_LATENCY - 1;
   localparam int unsigned WR_M1     = WR_LATENCY - 1;
   localparam int unsigned RS_M1     = RESP_CYCLES - 1;
   localparam int unsigned LAT_MAX   = (RD_M1 > WR_M1) ? RD_M1 : WR_M1;
   localparam int unsigned CNT_MAX   = (LAT_MAX > RS_M1) ? LAT_MAX : RS_M1;
   localparam int unsigned CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;
   typedef enum logic {K_READ, K_WRITE} kind_t;

   // Zero-initialised at time 0 only; reset never clears the array.
   logic [LINE_BITS-1:0] r_mem [DEPTH_LINES] = '{default: '0};

   state_t               r_state, w_state_nxt;
   kind_t                r_kind, w_kind_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]     r_idx;
   logic [LINE_BITS-1:0] r_wline;
   logic [LINE_BITS-1:0] r_rdata;
   logic                 r_proto_err, w_perr_nxt;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_accept, w_accept_wr, w_commit, w_load;
   logic                 w_unused_addr;

   // Line index; the offset bits and the bits above the array size are dropped,
   // so addresses wrap modulo the memory size.
   assign w_idx         = mem_addr[OFF +: IDX_W];
   assign w_unused_addr = ^mem_addr;

   always_comb begin
      w_state_nxt = r_state;
      w_kind_nxt  = r_kind;
      w_cnt_nxt   = r_cnt;
      w_perr_nxt  = 1'b0;
      w_accept    = 1'b0;
      w_accept_wr = 1'b0;
      w_commit    = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_write) begin
               w_accept    = 1'b1;
               w_accept_wr = 1'b1;
               w_kind_nxt  = K_WRITE;
               w_cnt_nxt   = CNT_W'(WR_M1);
               w_state_nxt = S_WAIT;
               w_perr_nxt  = mem_read;
            end else if (mem_read) begin
               w_accept    = 1'b1;
               w_kind_nxt  = K_READ;
               w_cnt_nxt   = CNT_W'(RD_M1);
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_state_nxt = S_RESP;
               w_cnt_nxt   = CNT_W'(RS_M1);
               w_commit    = (r_kind == K_WRITE);
               w_load      = (r_kind == K_READ);
            end
         end
         S_RESP: begin
            if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
            else             w_state_nxt = S_DONE;
         end
         S_DONE: begin
            // Only the serviced request line holds us here; the other is ignored.
            if (!((r_kind == K_WRITE) ? mem_write : mem_read)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_kind      <= K_READ;
         r_cnt       <= '0;
         r_rdata     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_kind      <= w_kind_nxt;
         r_cnt       <= w_cnt_nxt;
         r_proto_err <= w_perr_nxt;
         if (w_load) r_rdata <= r_mem[r_idx];
      end
   end

   // Request payload, captured on acceptance only.
   always_ff @(posedge clk) begin
      if (w_accept)    r_idx   <= w_idx;
      if (w_accept_wr) r_wline <= mem_wdata;
   end

   // Array write port kept reset-free; a reset on the commit edge still abandons
   // the write.
   always_ff @(posedge clk) begin
      if (w_commit && !rst) r_mem[r_idx] <= r_wline;
   end

   // ca_resp is a decode of the registered state, so it falls at the reset edge.
   assign ca_resp   = (r_state == S_RESP);
   assign mem_rdata = r_rdata;
   assign proto_err = r_proto_err;

endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder
//   Drives two responders from the same request lines:
//   - u0 uses the default latencies.
//   - u1 uses RD_LATENCY=1 and RESP_CYCLES=3.
//   A transaction-timeline model predicts ca_resp, mem_rdata and proto_err for
//   both every cycle. Directed scenarios add literal expectations; a random
//   phase follows.
module tb_main_mem_responder;

   localparam int LB = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_read, mem_write;
   logic [31:0]   mem_addr;
   logic [LB-1:0] mem_wdata;
   logic [LB-1:0] rdata0, rdata1;
   logic          resp0, resp1, perr0, perr1;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   always #5 clk = ~clk;

   main_mem_responder u0 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata0),
      .ca_resp(resp0), .proto_err(perr0)
   );

   main_mem_responder #(.RD_LATENCY(1), .RESP_CYCLES(3)) u1 (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata1),
      .ca_resp(resp1), .proto_err(perr1)
   );

   task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- reference model (transaction timeline) ----------------
   function automatic int rd_lat(int k);   return (k == 0) ? 4 : 1; endfunction
   function automatic int wr_lat(int k);   return 4;                endfunction
   function automatic int resp_len(int k); return (k == 0) ? 1 : 3; endfunction

   logic [LB-1:0] mdl_mem [2][256];
   bit            m_valid = 1'b0;
   longint        t = 0;
   bit            m_busy [2];
   longint        m_acc  [2];
   bit            m_wr   [2];
   int            m_idx  [2];
   int            m_lat  [2];
   logic [LB-1:0] m_line [2];
   logic [LB-1:0] e_rdata[2];
   bit            e_resp [2];
   bit            e_perr [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0;
         for (int i = 0; i < 256; i++) mdl_mem[k][i] = '0;
      end
   end

   always @(posedge clk) begin
      t++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_valid  = 1'b1;
            m_busy[k] = 1'b0;
            e_resp[k] = 1'b0;
            e_perr[k] = 1'b0;
            e_rdata[k] = '0;
         end else begin
            e_perr[k] = 1'b0;
            if (!m_busy[k]) begin
               if (mem_write || mem_read) begin
                  m_busy[k] = 1'b1;
                  m_acc[k]  = t;
                  m_wr[k]   = mem_write;
                  m_idx[k]  = int'((mem_addr / 32) % 256);
                  m_line[k] = mem_wdata;
                  m_lat[k]  = mem_write ? wr_lat(k) : rd_lat(k);
                  e_perr[k] = mem_write && mem_read;
               end
            end else begin
               if (t == m_acc[k] + m_lat[k]) begin
                  if (m_wr[k]) mdl_mem[k][m_idx[k]] = m_line[k];
                  else         e_rdata[k] = mdl_mem[k][m_idx[k]];
               end
               if (t >= m_acc[k] + m_lat[k] + resp_len(k) + 1 &&
                   !(m_wr[k] ? mem_write : mem_read))
                  m_busy[k] = 1'b0;
            end
            e_resp[k] = m_busy[k] && (t >= m_acc[k] + m_lat[k]) &&
                        (t < m_acc[k] + m_lat[k] + resp_len(k));
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("u0.ca_resp",   {255'd0, resp0}, {255'd0, e_resp[0]});
         chk("u0.mem_rdata", rdata0,          e_rdata[0]);
         chk("u0.proto_err", {255'd0, perr0}, {255'd0, e_perr[0]});
         chk("u1.ca_resp",   {255'd0, resp1}, {255'd0, e_resp[1]});
         chk("u1.mem_rdata", rdata1,          e_rdata[1]);
         chk("u1.proto_err", {255'd0, perr1}, {255'd0, e_perr[1]});
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic idle(input int n);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Raise the request now and follow u0 until its ca_resp falls.
   // lat counts cycles from the first edge after the request rises.
   task automatic xfer(input bit wr, input bit both, input logic [31:0] a,
                       input logic [LB-1:0] d, input bit drop,
                       output int lat, output int wid, output int pc);
      int n;
      bit seen;
      bit fell;
      n = 0; seen = 1'b0; fell = 1'b0; lat = -1; wid = 0; pc = 0;
      mem_addr  = a;
      mem_wdata = d;
      mem_write = wr || both;
      mem_read  = !wr || both;
      for (int c = 0; c < 100 && !fell; c++) begin
         @(negedge clk);
         n++;
         if (perr0) pc++;
         if (resp0) begin
            if (!seen) lat = n - 1;
            seen = 1'b1;
            wid++;
         end else if (seen) begin
            fell = 1'b1;
         end
      end
      chk("xfer.completed", {255'd0, fell}, {255'd0, 1'b1});
      if (drop) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   endtask

   initial begin
      logic [LB-1:0] pre, dead, pat3, newd, pw;
      logic [7:0]    v0, v1;
      int lat, wid, pc, c0, c1;

      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
      repeat (2) @(negedge clk);
      chk("reset.ca_resp",   {255'd0, resp0}, '0);
      chk("reset.mem_rdata", rdata0,          '0);
      chk("reset.proto_err", {255'd0, perr0}, '0);
      rst = 1'b0;
      idle(2);

      // 1: preload line 5 through a write, then read it back.
      for (int i = 0; i < 8; i++) pre[i*32 +: 32] = i;
      xfer(1'b1, 1'b0, 32'hA0, pre, 1'b1, lat, wid, pc);
      chk("t1.wr_latency", lat, 4);
      idle(6);
      xfer(1'b0, 1'b0, 32'hA0, '0, 1'b1, lat, wid, pc);
      chk("t1.rd_latency", lat, 4);
      chk("t1.resp_width", wid, 1);
      chk("t1.rdata",      rdata0, pre);
      chk("t1.no_perr",    pc, 0);
      idle(5);
      chk("t1.rdata_hold", rdata0, pre);

      // 2: write-back then fetch, with the request lines swapped in one cycle.
      dead = {8{32'hDEADBEEF}};
      xfer(1'b1, 1'b0, 32'h40, dead, 1'b0, lat, wid, pc);
      xfer(1'b0, 1'b0, 32'h40, '0,   1'b1, lat, wid, pc);
      chk("t2.fetch_latency", lat, 5);
      chk("t2.rdata",         rdata0, dead);
      idle(6);

      // 3: simultaneous read and write.
      for (int i = 0; i < 8; i++) pat3[i*32 +: 32] = 32'hA5A5_0000 + i;
      xfer(1'b1, 1'b1, 32'h60, pat3, 1'b1, lat, wid, pc);
      chk("t3.perr_cycles", pc, 1);
      idle(6);
      xfer(1'b0, 1'b0, 32'h60, '0, 1'b1, lat, wid, pc);
      chk("t3.rdata", rdata0, pat3);
      idle(6);

      // 4: reset two cycles into a write's latency.
      newd = {8{32'hFFFF0000}};
      mem_addr = 32'hA0; mem_wdata = newd; mem_write = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_write = 1'b0;
      c0 = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp0) c0++;
      end
      chk("t4.resp_after_reset", c0, 0);
      xfer(1'b0, 1'b0, 32'hA0, '0, 1'b1, lat, wid, pc);
      chk("t4.old_contents", rdata0, pre);
      idle(6);

      // 5: address wrap, then the short-latency instance's pulse timing.
      for (int i = 0; i < 8; i++) pw[i*32 +: 32] = 32'h0BAD_0000 + i;
      xfer(1'b1, 1'b0, 32'h2000, pw, 1'b1, lat, wid, pc);
      idle(6);
      xfer(1'b0, 1'b0, 32'h0, '0, 1'b1, lat, wid, pc);
      chk("t5.wrap_rdata", rdata0, pw);
      idle(8);
      mem_addr = 32'hA0; mem_read = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         v0[n] = resp0;
         v1[n] = resp1;
      end
      mem_read = 1'b0;
      chk("t5.u1_resp_pattern", {248'd0, v1}, {248'd0, 8'b0000_1110});
      chk("t5.u0_resp_pattern", {248'd0, v0}, {248'd0, 8'b0001_0000});
      chk("t5.u1_rdata",        rdata1, pre);
      idle(4);

      // 6: read held for 20 cycles.
      mem_addr = 32'h40; mem_read = 1'b1;
      c0 = 0; c1 = 0;
      repeat (20) begin
         @(negedge clk);
         if (resp0) c0++;
         if (resp1) c1++;
      end
      mem_read = 1'b0;
      chk("t6.u0_pulses", c0, 1);
      chk("t6.u1_pulses", c1, 3);
      idle(4);

      // Random phase: level requests, occasional resets, wrapping addresses.
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 7) == 0) mem_read  = ~mem_read;
         if ($urandom_range(0, 9) == 0) mem_write = ~mem_write;
         if ($urandom_range(0, 3) == 0)
            mem_addr = ($urandom & 32'hFFFF_E01F) | ($urandom_range(0, 7) << 5);
         if ($urandom_range(0, 3) == 0)
            for (int w = 0; w < 8; w++) mem_wdata[w*32 +: 32] = $urandom;
         @(negedge clk);
      end
      rst = 1'b0;
      idle(20);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Line-granular main-memory model/responder on the memory side of the cache-to-memory interface (mem_read / mem_write / ca_resp).
- Accepts one line read or line write at a time, waits a fixed latency, then signals completion with a self-timed ca_resp pulse.
- Serves as the backing store for the 2-way cache controller in simulation; also synthesisable as a BRAM-backed memory.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WORD_WIDTH, 32, bits per word.
- LINE_WORDS, 8, words per cache line (power of 2).
- DEPTH_LINES, 256, number of lines stored (power of 2).
- RD_LATENCY, 4, cycles from read acceptance to first ca_resp cycle (>=1).
- WR_LATENCY, 4, cycles from write acceptance to first ca_resp cycle (>=1).
- RESP_CYCLES, 1, width of the ca_resp pulse in cycles (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- mem_read  in  1  line read request, level.
- mem_write  in  1  line write request, level.
- mem_addr  in  ADDR_WIDTH  byte address; offset bits ignored.
- mem_wdata  in  LINE_WORDS*WORD_WIDTH  write line; word 0 in the LSBs.
- mem_rdata  out  LINE_WORDS*WORD_WIDTH  read line, registered.
- ca_resp  out  1  completion pulse.
- proto_err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset: state IDLE, counter 0, ca_resp 0, mem_rdata 0, proto_err 0. The array is not cleared; it is zero-initialised at time 0 only.
- Reset mid-operation abandons the transaction. A write still in latency is not committed. ca_resp drops at the reset edge.
- Line index: mem_addr[OFF +: log2(DEPTH_LINES)], where OFF = log2(LINE_WORDS*WORD_WIDTH/8). Upper bits are ignored, so addresses wrap modulo the memory size.
- States: IDLE, WAIT, RESP, DONE.
- IDLE:
  - On mem_write=1: latch index and mem_wdata, set kind=WRITE, counter=WR_LATENCY-1, go to WAIT.
  - Else on mem_read=1: latch index, set kind=READ, counter=RD_LATENCY-1, go to WAIT.
  - If both are 1: the write wins and proto_err pulses for 1 cycle.
- WAIT:
  - While counter != 0, decrement.
  - At counter == 0: go to RESP and set ca_resp=1.
  - On that same edge, a WRITE commits the latched line to the array; a READ loads mem_rdata from the array.
  - ca_resp therefore first appears exactly L cycles after the accepting edge (L = RD_LATENCY or WR_LATENCY).
- RESP:
  - ca_resp held for RESP_CYCLES cycles, then cleared and go to DONE.
  - ca_resp is never gated by the request line. The initiator may hold its request through the pulse and detects completion on the falling edge.
- DONE:
  - Stay while the serviced request line (mem_read for READ, mem_write for WRITE) is still 1, then return to IDLE.
  - The other request line is ignored in DONE. The write-back-then-fetch transition (mem_write falls while mem_read rises in the same cycle) leaves DONE after 1 cycle, and the read is accepted in IDLE on the next edge.
- Request dropped during WAIT or RESP: no abort. The transaction completes normally and DONE exits immediately.
- Request lines are not sampled outside IDLE/DONE. No second transaction is accepted while busy.
- mem_rdata holds its value until the next READ response edge. A WRITE does not alter mem_rdata.
- Ordering: a committed write is visible to any read accepted afterwards.
- No X propagation on outputs: unknown request inputs are treated as 0.

Test Plan:
1. Read: preload line 5 with 0x0000_0000..0x0000_0007 (word i = i), pulse mem_read with addr 0xA0 → ca_resp high exactly 4 cycles after the accepting edge, for 1 cycle; mem_rdata equals the preload, stable until the next read.
2. Write-back then fetch: hold mem_write with addr 0x40 and data all-0xDEADBEEF. When ca_resp falls, drop mem_write and raise mem_read with addr 0x40 in the same cycle → read accepted 1 cycle later; second ca_resp after 4 more cycles; mem_rdata is all-0xDEADBEEF.
3. Simultaneous: mem_read=mem_write=1 in IDLE → proto_err is a 1-cycle pulse; the write is performed; a later read returns the written data.
4. Reset mid-latency: write accepted, rst asserted 2 cycles later → ca_resp stays 0; a read of that line afterwards returns the old contents.
5. Wrap and latency params: DEPTH_LINES=256, addr 0x2000 aliases addr 0x0 (write to 0x2000, read 0x0 returns same line). With RD_LATENCY=1 and RESP_CYCLES=3, ca_resp is high on cycles 1–3 after acceptance.
6. Held request: mem_read held high for 20 cycles → exactly one ca_resp pulse; no re-trigger until mem_read drops.
